// File: rtl/l1b_onbellek_pkg.sv
// Shared types and default geometry for the l1b instruction cache.
package l1b_onbellek_pkg;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    ISTEK  = 2'd1,
    DOLDUR = 2'd2
  } durum_t;

  localparam int VARSAYILAN_SATIR_SAYISI = 64;
  localparam int VARSAYILAN_SATIR_KELIME = 4;
  localparam int VARSAYILAN_ADRES_BIT    = 32;
  localparam int KELIME_BIT              = 32;

endpackage

// File: rtl/l1b_onbellek_if.sv
// Core fetch port plus main-memory read bus seen by the l1b cache.
interface l1b_onbellek_if #(
  parameter int ADRES_BIT = 32
);
  import l1b_onbellek_pkg::*;

  logic                  l1b_chip_select_n_i;
  logic [ADRES_BIT-1:0]  l1b_adres_i;
  logic [KELIME_BIT-1:0] l1b_deger_o;
  logic                  l1b_bekle_o;
  logic                  temizle_i;
  logic                  bel_istek_o;
  logic [ADRES_BIT-1:0]  bel_adres_o;
  logic                  bel_hazir_i;
  logic                  bel_gecerli_i;
  logic [KELIME_BIT-1:0] bel_deger_i;

  // slave: the cache itself; master: core fetch unit and memory controller
  modport slave (
    input  l1b_chip_select_n_i, l1b_adres_i, temizle_i,
    input  bel_hazir_i, bel_gecerli_i, bel_deger_i,
    output l1b_deger_o, l1b_bekle_o, bel_istek_o, bel_adres_o
  );

  modport master (
    output l1b_chip_select_n_i, l1b_adres_i, temizle_i,
    output bel_hazir_i, bel_gecerli_i, bel_deger_i,
    input  l1b_deger_o, l1b_bekle_o, bel_istek_o, bel_adres_o
  );

endinterface

// File: rtl/l1b_onbellek_bellek.sv
// Valid/tag/data storage: combinational read, one-word fill write, tag set, flush-all.
module l1b_onbellek_bellek
  import l1b_onbellek_pkg::*;
#(
  parameter int SATIR_SAYISI = VARSAYILAN_SATIR_SAYISI,
  parameter int SATIR_KELIME = VARSAYILAN_SATIR_KELIME,
  parameter int ETIKET_BIT   = 22,
  localparam int IDX_W       = $clog2(SATIR_SAYISI),
  localparam int OFS_W       = $clog2(SATIR_KELIME)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      oku_indeks,
  input  logic [OFS_W-1:0]      oku_ofset,
  output logic                  oku_gecerli,
  output logic [ETIKET_BIT-1:0] oku_etiket,
  output logic [KELIME_BIT-1:0] oku_veri,
  input  logic                  yaz_en,
  input  logic [IDX_W-1:0]      yaz_indeks,
  input  logic [OFS_W-1:0]      yaz_ofset,
  input  logic [KELIME_BIT-1:0] yaz_veri,
  input  logic                  etiket_yaz_en,
  input  logic [ETIKET_BIT-1:0] yaz_etiket,
  input  logic                  temizle
);

  logic [SATIR_SAYISI-1:0]                 gecerli;
  logic [ETIKET_BIT-1:0]                   etiket [SATIR_SAYISI];
  logic [SATIR_KELIME-1:0][KELIME_BIT-1:0] veri   [SATIR_SAYISI];

  assign oku_gecerli = gecerli[oku_indeks];
  assign oku_etiket  = etiket[oku_indeks];
  assign oku_veri    = veri[oku_indeks][oku_ofset];

  // Flush beats a same-cycle tag set, so a line finishing under fence.i stays invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i)              gecerli <= '0;
    else if (temizle)       gecerli <= '0;
    else if (etiket_yaz_en) gecerli[yaz_indeks] <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (yaz_en)        veri[yaz_indeks][yaz_ofset] <= yaz_veri;
    if (etiket_yaz_en) etiket[yaz_indeks]          <= yaz_etiket;
  end

endmodule

// File: rtl/l1b_onbellek.sv
// Direct-mapped read-only L1 instruction cache: zero-wait hits, in-order line fill on miss.
module l1b_onbellek
  import l1b_onbellek_pkg::*;
#(
  parameter int SATIR_SAYISI = VARSAYILAN_SATIR_SAYISI,
  parameter int SATIR_KELIME = VARSAYILAN_SATIR_KELIME,
  parameter int ADRES_BIT    = VARSAYILAN_ADRES_BIT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  l1b_onbellek_if.slave bus
);

  localparam int OFS_W   = $clog2(SATIR_KELIME);
  localparam int IDX_W   = $clog2(SATIR_SAYISI);
  localparam int SATIR_W = ADRES_BIT - OFS_W - 2;
  localparam int TAG_W   = SATIR_W - IDX_W;
  localparam logic [OFS_W-1:0] SON_KELIME = OFS_W'(SATIR_KELIME - 1);

  durum_t               durum;
  logic [SATIR_W-1:0]   satir_q;
  logic [OFS_W-1:0]     sayac;
  logic [OFS_W-1:0]     sayac_art;
  logic                 zehirli;
  logic                 istek_q;
  logic [ADRES_BIT-1:0] adres_q;

  logic [SATIR_W-1:0]    satir_no;
  logic [OFS_W-1:0]      ofset;
  logic [IDX_W-1:0]      indeks;
  logic [TAG_W-1:0]      etiket;
  logic                  oku_gecerli;
  logic [TAG_W-1:0]      oku_etiket;
  logic [KELIME_BIT-1:0] oku_veri;
  logic                  istek_var, isabet, yaz_en, son_yaz;
  logic [1:0]            unused_bayt;

  assign satir_no    = bus.l1b_adres_i[ADRES_BIT-1:OFS_W+2];
  assign ofset       = bus.l1b_adres_i[OFS_W+1:2];
  assign indeks      = satir_no[IDX_W-1:0];
  assign etiket      = satir_no[SATIR_W-1:IDX_W];
  assign unused_bayt = bus.l1b_adres_i[1:0];

  assign istek_var       = !bus.l1b_chip_select_n_i;
  assign isabet          = istek_var && durum == BOSTA && oku_gecerli && oku_etiket == etiket;
  assign bus.l1b_bekle_o = istek_var && !isabet;
  assign bus.l1b_deger_o = istek_var ? oku_veri : '0;
  assign bus.bel_istek_o = istek_q;
  assign bus.bel_adres_o = adres_q;

  assign yaz_en    = durum == DOLDUR && bus.bel_gecerli_i;
  assign son_yaz   = yaz_en && sayac == SON_KELIME;
  assign sayac_art = sayac + 1'b1;

  // The fill runs from satir_q only, so the core address may wander without harm.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum   <= BOSTA;
      satir_q <= '0;
      sayac   <= '0;
      zehirli <= 1'b0;
      istek_q <= 1'b0;
      adres_q <= '0;
    end else begin
      if (bus.temizle_i && durum != BOSTA) zehirli <= 1'b1;
      unique case (durum)
        BOSTA: begin
          if (bus.l1b_bekle_o) begin
            satir_q <= satir_no;
            sayac   <= '0;
            istek_q <= 1'b1;
            adres_q <= {satir_no, {OFS_W{1'b0}}, 2'b00};
            durum   <= ISTEK;
          end
        end
        ISTEK: begin
          if (bus.bel_hazir_i) begin
            istek_q <= 1'b0;
            durum   <= DOLDUR;
          end
        end
        DOLDUR: begin
          if (bus.bel_gecerli_i) begin
            if (sayac == SON_KELIME) begin
              zehirli <= 1'b0;
              durum   <= BOSTA;
            end else begin
              sayac   <= sayac_art;
              istek_q <= 1'b1;
              adres_q <= {satir_q, sayac_art, 2'b00};
              durum   <= ISTEK;
            end
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end

  l1b_onbellek_bellek #(
    .SATIR_SAYISI (SATIR_SAYISI),
    .SATIR_KELIME (SATIR_KELIME),
    .ETIKET_BIT   (TAG_W)
  ) u_bellek (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .oku_indeks    (indeks),
    .oku_ofset     (ofset),
    .oku_gecerli   (oku_gecerli),
    .oku_etiket    (oku_etiket),
    .oku_veri      (oku_veri),
    .yaz_en        (yaz_en),
    .yaz_indeks    (satir_q[IDX_W-1:0]),
    .yaz_ofset     (sayac),
    .yaz_veri      (bus.bel_deger_i),
    .etiket_yaz_en (son_yaz && !zehirli),
    .yaz_etiket    (satir_q[SATIR_W-1:IDX_W]),
    .temizle       (bus.temizle_i)
  );

endmodule
